cuckoo_hash_table: RTL

Parametrised two-table cuckoo hash store with a single-operation request/response handshake. It supports insert, lookup and delete; the caller supplies both bucket indices. Displacement chains run as a bounded, clocked kick loop with an explicit failure report. It sits between the hash-index generator and downstream consumers, and serves as the team's general key store.

---
 rtl/cuckoo_pkg.sv | 31 +++
 rtl/cuckoo_bank.sv | 47 ++++
 rtl/cuckoo_hash_table.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cuckoo_pkg.sv
// Shared definitions for the two-table cuckoo hash store.
package cuckoo_pkg;

    // Default geometry; modules override through their own parameters.
    localparam int PKG_KEY_W = 32;
    localparam int PKG_IDX_W = 5;

    // Request op codes (3 is reserved and behaves as a lookup).
    localparam logic [1:0] OP_INSERT = 2'd0;
    localparam logic [1:0] OP_LOOKUP = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_KICK  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Stored entry: alt_idx is the bucket this key would use in the other table.
    typedef struct packed {
        logic                 valid;
        logic [PKG_KEY_W-1:0] key;
        logic [PKG_IDX_W-1:0] alt_idx;
    } entry_t;

    // Width of a counter that must hold 0..max_kicks.
    function automatic int kick_w(input int max_kicks);
        return $clog2(max_kicks + 1);
    endfunction

endpackage

// File: rtl/cuckoo_bank.sv
// One cuckoo table: synchronous write port, combinational read port.
module cuckoo_bank
    import cuckoo_pkg::*;
#(
    parameter int KEY_W = PKG_KEY_W,
    parameter int IDX_W = PKG_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic             i_wvalid,
    input  logic [KEY_W-1:0] i_wkey,
    input  logic [IDX_W-1:0] i_walt,
    input  logic [IDX_W-1:0] i_raddr,
    output logic             o_rvalid,
    output logic [KEY_W-1:0] o_rkey,
    output logic [IDX_W-1:0] o_ralt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] r_valid;
    logic [KEY_W-1:0] r_key [DEPTH];
    logic [IDX_W-1:0] r_alt [DEPTH];

    // Valid bits are the only state reset needs to touch.
    always_ff @(posedge clk) begin
        if (rst)
            r_valid <= '0;
        else if (i_we)
            r_valid[i_waddr] <= i_wvalid;
    end

    // Key/alt payload storage; contents are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_key[i_waddr] <= i_wkey;
            r_alt[i_waddr] <= i_walt;
        end
    end

    assign o_rvalid = r_valid[i_raddr];
    assign o_rkey   = r_key[i_raddr];
    assign o_ralt   = r_alt[i_raddr];

endmodule

// File: rtl/cuckoo_hash_table.sv
// Two-table cuckoo hash store with bounded, clocked displacement chains.
module cuckoo_hash_table
    import cuckoo_pkg::*;
#(
    parameter int KEY_W     = PKG_KEY_W,
    parameter int IDX_W     = PKG_IDX_W,
    parameter int MAX_KICKS = 16,
    localparam int KW       = kick_w(MAX_KICKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [KEY_W-1:0] op_key,
    input  logic [IDX_W-1:0] op_idx1,
    input  logic [IDX_W-1:0] op_idx2,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_fail,
    output logic [KEY_W-1:0] resp_key,
    output logic [KW-1:0]    resp_kicks,
    output logic [IDX_W+1:0] count
);

    // Entry layout sized by this instance's parameters.
    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] alt_idx;
    } ent_t;

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [KEY_W-1:0] r_key;
    logic [IDX_W-1:0] r_idx1;
    logic [IDX_W-1:0] r_idx2;
    // Carried (homeless) key: r_carry_alt is its bucket in the target table,
    // r_carry_src the bucket it was evicted from (stored as alt on placement).
    logic [KEY_W-1:0] r_carry_key;
    logic [IDX_W-1:0] r_carry_alt;
    logic [IDX_W-1:0] r_carry_src;
    logic             r_carry_t2;   // 1: carry came from table 2, goes to table 1
    logic [KW-1:0]    r_kicks;
    logic [IDX_W+1:0] r_count;
    logic             r_resp_valid;
    logic             r_resp_hit;
    logic             r_resp_fail;
    logic [KEY_W-1:0] r_resp_key;
    logic [KW-1:0]    r_resp_kicks;

    logic             w_t1_we, w_t2_we;
    ent_t             w_t1_wd, w_t2_wd;
    logic [IDX_W-1:0] w_t1_wa, w_t2_wa;
    logic [IDX_W-1:0] w_t1_ra, w_t2_ra;
    ent_t             w_t1_rd, w_t2_rd;
    logic             w_m1, w_m2, w_match;
    logic             w_tgt_valid;
    ent_t             w_tgt;
    logic             w_kick_fail;

    // In KICK the read ports look at the carry's target bucket instead of the op's.
    assign w_t1_ra = (r_state == ST_KICK) ? r_carry_alt : r_idx1;
    assign w_t2_ra = (r_state == ST_KICK) ? r_carry_alt : r_idx2;

    cuckoo_bank #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_t1 (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_t1_we),
        .i_waddr  (w_t1_wa),
        .i_wvalid (w_t1_wd.valid),
        .i_wkey   (w_t1_wd.key),
        .i_walt   (w_t1_wd.alt_idx),
        .i_raddr  (w_t1_ra),
        .o_rvalid (w_t1_rd.valid),
        .o_rkey   (w_t1_rd.key),
        .o_ralt   (w_t1_rd.alt_idx)
    );

    cuckoo_bank #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_t2 (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_t2_we),
        .i_waddr  (w_t2_wa),
        .i_wvalid (w_t2_wd.valid),
        .i_wkey   (w_t2_wd.key),
        .i_walt   (w_t2_wd.alt_idx),
        .i_raddr  (w_t2_ra),
        .o_rvalid (w_t2_rd.valid),
        .o_rkey   (w_t2_rd.key),
        .o_ralt   (w_t2_rd.alt_idx)
    );

    assign w_m1        = w_t1_rd.valid && (w_t1_rd.key == r_key);
    assign w_m2        = w_t2_rd.valid && (w_t2_rd.key == r_key);
    assign w_match     = w_m1 || w_m2;
    assign w_tgt       = r_carry_t2 ? w_t1_rd : w_t2_rd;
    assign w_tgt_valid = w_tgt.valid;
    // Budget exhausted and nowhere to put the carry: give up without moving it.
    assign w_kick_fail = w_tgt_valid && (r_kicks == KW'(MAX_KICKS));

    // Table write decode for probe placement, delete and kick moves.
    always_comb begin
        w_t1_we = 1'b0;
        w_t2_we = 1'b0;
        w_t1_wa = r_idx1;
        w_t2_wa = r_idx2;
        w_t1_wd = '{valid: 1'b1, key: r_key, alt_idx: r_idx2};
        w_t2_wd = '{valid: 1'b1, key: r_key, alt_idx: r_idx1};
        case (r_state)
            ST_PROBE: begin
                if (r_op == OP_INSERT && !w_match) begin
                    // t1 first; t2 only if t1 is taken; both taken evicts t1.
                    if (w_t1_rd.valid && !w_t2_rd.valid)
                        w_t2_we = 1'b1;
                    else
                        w_t1_we = 1'b1;
                end else if (r_op == OP_DELETE) begin
                    if (w_m1) begin
                        w_t1_we = 1'b1;
                        w_t1_wd = '{valid: 1'b0, key: w_t1_rd.key, alt_idx: w_t1_rd.alt_idx};
                    end else if (w_m2) begin
                        w_t2_we = 1'b1;
                        w_t2_wd = '{valid: 1'b0, key: w_t2_rd.key, alt_idx: w_t2_rd.alt_idx};
                    end
                end
            end
            ST_KICK: begin
                if (!w_kick_fail) begin
                    if (r_carry_t2) begin
                        w_t1_we = 1'b1;
                        w_t1_wa = r_carry_alt;
                        w_t1_wd = '{valid: 1'b1, key: r_carry_key, alt_idx: r_carry_src};
                    end else begin
                        w_t2_we = 1'b1;
                        w_t2_wa = r_carry_alt;
                        w_t2_wd = '{valid: 1'b1, key: r_carry_key, alt_idx: r_carry_src};
                    end
                end
            end
            default: ;
        endcase
    end

    // Controller: request capture, probe outcome, kick chain and response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_INSERT;
            r_key        <= '0;
            r_idx1       <= '0;
            r_idx2       <= '0;
            r_carry_key  <= '0;
            r_carry_alt  <= '0;
            r_carry_src  <= '0;
            r_carry_t2   <= 1'b0;
            r_kicks      <= '0;
            r_count      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_fail  <= 1'b0;
            r_resp_key   <= '0;
            r_resp_kicks <= '0;
        end else begin
            // Response fields are a one-cycle pulse; zero unless set below.
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_fail  <= 1'b0;
            r_resp_key   <= '0;
            r_resp_kicks <= '0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (op_valid) begin
                        r_state <= ST_PROBE;
                        r_op    <= op_code;
                        r_key   <= op_key;
                        r_idx1  <= op_idx1;
                        r_idx2  <= op_idx2;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PROBE: begin
                    r_resp_key <= r_key;
                    if (r_op == OP_INSERT && !w_match &&
                        w_t1_rd.valid && w_t2_rd.valid) begin
                        r_state      <= ST_KICK;
                        r_carry_key  <= w_t1_rd.key;
                        r_carry_alt  <= w_t1_rd.alt_idx;
                        r_carry_src  <= r_idx1;
                        r_carry_t2   <= 1'b0;
                        r_kicks      <= KW'(1);
                        r_resp_key   <= '0;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= w_match;
                        if (r_op == OP_INSERT && !w_match)
                            r_count <= r_count + 1'b1;
                        else if (r_op == OP_DELETE && w_match)
                            r_count <= r_count - 1'b1;
                    end
                end
                ST_KICK: begin
                    if (!w_tgt_valid) begin
                        r_state      <= ST_RESP;
                        r_count      <= r_count + 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_key   <= r_key;
                        r_resp_kicks <= r_kicks;
                    end else if (w_kick_fail) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_fail  <= 1'b1;
                        r_resp_key   <= r_carry_key;
                        r_resp_kicks <= r_kicks;
                    end else begin
                        // Swap: the evicted occupant becomes the new carry.
                        r_carry_key <= w_tgt.key;
                        r_carry_alt <= w_tgt.alt_idx;
                        r_carry_src <= r_carry_alt;
                        r_carry_t2  <= ~r_carry_t2;
                        r_kicks     <= r_kicks + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign op_ready   = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_fail  = r_resp_fail;
    assign resp_key   = r_resp_key;
    assign resp_kicks = r_resp_kicks;
    assign count      = r_count;

endmodule
